// File: rtl/segment_transition_ctl_if.sv
// Request/status bundle between the segment sampler controller and its host.
// The master modport is the host side; the slave modport is the controller side.
interface segment_transition_ctl_if #(
  parameter int NUM_SEGMENT    = 4,
  parameter int SYS_TIME_WIDTH = 56,
  parameter int NUM_GPIO       = 4
);
  localparam int SW = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1;

  logic                      update_settings;
  logic [SW-1:0]             req_segment;
  logic [15:0]               rep;
  logic [7:0]                transition_mode;
  logic [63:0]               transition_value;
  logic [SYS_TIME_WIDTH-1:0] sys_time;
  logic [NUM_GPIO-1:0]       gpio_in;
  logic                      idx_wrap;
  logic [SW-1:0]             segment;
  logic                      swap;
  logic                      stop;
  logic                      pending;
  logic                      req_err;

  modport master (
    output update_settings, req_segment, rep, transition_mode, transition_value,
    output sys_time, gpio_in, idx_wrap,
    input  segment, swap, stop, pending, req_err
  );

  modport slave (
    input  update_settings, req_segment, rep, transition_mode, transition_value,
    input  sys_time, gpio_in, idx_wrap,
    output segment, swap, stop, pending, req_err
  );
endinterface

// File: rtl/segment_transition_ctl.sv
// Selects the active memory segment and switches it on a trigger; trigger-to-segment latency 1 cycle.
// No backpressure: every request strobe is either accepted or flagged via the sticky error bit.
module segment_transition_ctl #(
  parameter int NUM_SEGMENT    = 4,
  parameter int SYS_TIME_WIDTH = 56,
  parameter int NUM_GPIO       = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  segment_transition_ctl_if.slave bus
);
  localparam int SW = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1;
  localparam int GW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

  localparam logic [7:0]    MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0]    MODE_SYS_TIME = 8'h01;
  localparam logic [7:0]    MODE_GPIO     = 8'h02;
  localparam logic [7:0]    MODE_EXT      = 8'hF0;
  localparam logic [15:0]   REP_INF       = 16'hFFFF;
  localparam logic [31:0]   SEG_LIMIT     = NUM_SEGMENT;
  localparam logic [SW-1:0] SEG_LAST      = SW'(NUM_SEGMENT - 1);

  typedef enum logic [1:0] {RUN_INF, WAIT_TRIG, RUN_FIN, STOPPED} state_t;

  state_t                    state;
  logic [SW-1:0]             lat_seg;
  logic [15:0]               lat_rep;
  logic [7:0]                lat_mode;
  logic [SYS_TIME_WIDTH-1:0] lat_time;
  logic [GW-1:0]             lat_gpio;
  logic [15:0]               loop_cnt;
  logic [NUM_GPIO-1:0]       gpio_q;

  logic seg_ok;
  logic mode_ok;
  logic req_ok;
  logic gpio_rise;
  logic trig;
  logic unused_value_bits;

  assign unused_value_bits = ^bus.transition_value;

  always_comb begin
    seg_ok    = ({{(32-SW){1'b0}}, bus.req_segment} < SEG_LIMIT);
    mode_ok   = (bus.transition_mode == MODE_SYNC_IDX) || (bus.transition_mode == MODE_SYS_TIME) ||
                (bus.transition_mode == MODE_GPIO)     || (bus.transition_mode == MODE_EXT);
    // Mode is irrelevant for infinite requests, so it cannot make them fail.
    req_ok    = seg_ok && (mode_ok || (bus.rep == REP_INF));
    gpio_rise = bus.gpio_in[lat_gpio] & ~gpio_q[lat_gpio];
    trig      = 1'b0;
    case (lat_mode)
      MODE_SYNC_IDX: trig = bus.idx_wrap;
      MODE_SYS_TIME: trig = (bus.sys_time >= lat_time);
      MODE_GPIO:     trig = gpio_rise;
      MODE_EXT:      trig = 1'b1;
      default:       trig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN_INF;
      bus.segment <= '0;
      bus.swap    <= 1'b0;
      bus.stop    <= 1'b0;
      bus.pending <= 1'b0;
      bus.req_err <= 1'b0;
      lat_seg     <= '0;
      lat_rep     <= '0;
      lat_mode    <= '0;
      lat_time    <= '0;
      lat_gpio    <= '0;
      loop_cnt    <= '0;
      gpio_q      <= '0;
    end else begin
      gpio_q   <= bus.gpio_in;
      bus.swap <= 1'b0;
      // A request outranks wraps and triggers in the same cycle.
      if (bus.update_settings) begin
        if (!req_ok) begin
          bus.req_err <= 1'b1;
        end else if (bus.rep == REP_INF) begin
          bus.req_err <= 1'b0;
          bus.segment <= bus.req_segment;
          bus.swap    <= 1'b1;
          bus.stop    <= 1'b0;
          bus.pending <= 1'b0;
          state       <= RUN_INF;
        end else begin
          bus.req_err <= 1'b0;
          bus.stop    <= 1'b0;
          bus.pending <= 1'b1;
          lat_seg     <= bus.req_segment;
          lat_rep     <= bus.rep;
          lat_mode    <= bus.transition_mode;
          lat_time    <= bus.transition_value[SYS_TIME_WIDTH-1:0];
          lat_gpio    <= bus.transition_value[GW-1:0];
          state       <= WAIT_TRIG;
        end
      end else begin
        case (state)
          WAIT_TRIG: begin
            if (trig) begin
              bus.segment <= lat_seg;
              bus.swap    <= 1'b1;
              bus.pending <= 1'b0;
              loop_cnt    <= '0;
              state       <= RUN_FIN;
            end
          end
          RUN_FIN: begin
            if (bus.idx_wrap) begin
              if (loop_cnt != lat_rep) begin
                loop_cnt <= loop_cnt + 16'd1;
              end else if (lat_mode == MODE_EXT) begin
                bus.segment <= (bus.segment == SEG_LAST) ? '0 : bus.segment + SW'(1);
                bus.swap    <= 1'b1;
                loop_cnt    <= '0;
              end else begin
                bus.stop <= 1'b1;
                state    <= STOPPED;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
